regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file. Successor to the single-write, two-read register file in the RISC-V core.
- Supports configurable width, depth, and read/write port counts.
- Optional write-to-read bypass and an optionally hardwired zero register.
- Adds a valid/ready register-dump sequencer. The end-of-test bench and the debug path use it to stream out all register contents.

Parameters:
- XLEN, 32, data width of each register.
- DEPTH, 32, number of registers (power of two, >= 2); localparam AW = $clog2(DEPTH).
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- BYPASS, 1, 1 = a read of an address being written this cycle returns the new data.
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rd_addr  input  NUM_RD*AW  packed read addresses; port i = bits [i*AW +: AW].
- rd_data  output  NUM_RD*XLEN  packed read data, combinational.
- wr_en  input  NUM_WR  per-port write enable.
- wr_addr  input  NUM_WR*AW  packed write addresses.
- wr_data  input  NUM_WR*XLEN  packed write data.
- dump_start  input  1  single-cycle request to start a dump.
- dump_valid  output  1  dump beat valid.
- dump_ready  input  1  consumer accepts the beat.
- dump_addr  output  AW  register index of the current beat.
- dump_data  output  XLEN  stored contents of register dump_addr.
- dump_busy  output  1  sequencer is not IDLE.
- dump_done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset: while reset_n = 0, all registers, the dump FSM and the index are cleared immediately.
  - Outputs during reset: dump_valid = 0, dump_busy = 0, dump_done = 0, dump_addr = 0, dump_data = 0.
  - rd_data reads 0 for every address.
- Writes:
  - Port w writes wr_data[w] into wr_addr[w] on the rising edge when wr_en[w] = 1. Write latency is 1 cycle.
  - Same-address conflict: if several enabled ports target one address, the highest port index wins.
  - If ZERO_REG = 1, writes to address 0 are dropped.
- Reads:
  - Combinational, zero latency.
  - If BYPASS = 1 and an enabled write port targets the read address this cycle, rd_data returns that port's wr_data. Multiple matches follow the same highest-index priority.
  - If BYPASS = 0, reads return the stored value; new data is visible the cycle after the write.
  - Address 0 with ZERO_REG = 1 returns 0, even when bypassing.
- Dump FSM, three states:
  - IDLE: on dump_start, go to RUN with idx = 0.
  - RUN:
    - dump_valid = 1, dump_addr = idx, dump_data = stored[idx]. Bypass is not applied.
    - On dump_valid & dump_ready: if idx = DEPTH-1, go to DONE; otherwise idx + 1.
    - While ready = 0, dump_addr is held. dump_data tracks the stored value, so a write landing mid-stall is seen.
  - DONE: dump_done = 1 for exactly one cycle, then IDLE.
  - dump_busy = 1 in RUN and DONE.
  - dump_start is ignored while busy; no restart and no queueing.
  - Normal reads and writes are fully independent of the dump and stay legal throughout.
- Reset mid-dump: abort immediately to IDLE with no dump_done pulse.
- Widths:
  - The index counter is AW+1 bits internally, so there is no wrap-around ambiguity at DEPTH-1.
  - Out-of-range addresses cannot occur because DEPTH is a power of two.

Decomposition:
- Package regfile_pkg holds:
  - default XLEN/DEPTH constants;
  - the dump_state_t enum {DUMP_IDLE, DUMP_RUN, DUMP_DONE};
  - a function for write-port priority resolution shared by the write and bypass logic.
- One sub-module, rf_dump_seq, holds the FSM and index counter. It drives dump_addr and handshake signals; regfile_mp muxes dump_data from storage.

Test Plan:
- Write port 0: x3 = 0xABCDEFFF, then x5 = 0xFBCDE111 -> next cycle, rd_addr = {5, 3} reads 0xFBCDE111 / 0xABCDEFFF. Unwritten x7 and x10 read 0.
- Write x0 = 0xFFFFFFFF with ZERO_REG = 1 -> x0 reads 0, including the bypass path in the same cycle.
- Same cycle, port 0 writes x9 = 0x11111111 and port 1 writes x9 = 0x22222222 -> x9 = 0x22222222. The bypass read that cycle also returns 0x22222222.
- BYPASS = 1: write x4 = 0x1234 and read x4 in the same cycle -> 0x1234 combinationally. With BYPASS = 0, the old value is returned until the next cycle.
- Preload xi = i*0x10, pulse dump_start, hold dump_ready low every other cycle ->
  - 32 accepted beats with addr 0..31 and data i*0x10 (x0 = 0);
  - dump_done pulses once, one cycle after beat 31;
  - a second dump_start sent mid-dump is ignored.
- Assert reset_n = 0 at beat 10 of a dump ->
  - valid, busy and done drop immediately;
  - all registers read 0;
  - a fresh dump_start afterwards restarts from addr 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its dump sequencer.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned DEPTH_DEF = 32;
  localparam int unsigned MAX_WR    = 16;
  localparam int unsigned PW        = $clog2(MAX_WR);

  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_RUN,
    DUMP_DONE
  } dump_state_t;

  typedef struct packed {
    logic          hit;
    logic [PW-1:0] port;
  } wr_sel_t;

  // Highest-index matching write port wins; used by both storage update and bypass.
  function automatic wr_sel_t wr_resolve(input logic [MAX_WR-1:0] match);
    wr_sel_t sel;
    sel = '0;
    for (int unsigned w = 0; w < MAX_WR; w++) begin
      if (match[w]) begin
        sel.hit  = 1'b1;
        sel.port = PW'(w);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rf_dump_seq.sv
// Dump sequencer: walks register indices 0..DEPTH-1 over a valid/ready stream.
module rf_dump_seq
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          dump_start,
  input  logic          dump_ready,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic          dump_busy,
  output logic          dump_done
);

  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  dump_state_t state_q, state_d;
  logic [AW:0] idx_q, idx_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    dump_done  = 1'b0;
    unique case (state_q)
      DUMP_IDLE: begin
        if (dump_start) begin
          state_d = DUMP_RUN;
          idx_d   = '0;
        end
      end
      DUMP_RUN: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        if (dump_ready) begin
          if (idx_q == LAST) begin
            state_d = DUMP_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + (AW+1)'(1);
          end
        end
      end
      DUMP_DONE: begin
        dump_busy = 1'b1;
        dump_done = 1'b1;
        state_d   = DUMP_IDLE;
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  assign dump_addr = idx_q[AW-1:0];

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional bypass, zero register and dump port.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN     = XLEN_DEF,
  parameter  int unsigned DEPTH    = DEPTH_DEF,
  parameter  int unsigned NUM_RD   = 2,
  parameter  int unsigned NUM_WR   = 2,
  parameter  bit          BYPASS   = 1'b1,
  parameter  bit          ZERO_REG = 1'b1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   dump_start,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic [AW-1:0]          dump_addr,
  output logic [XLEN-1:0]        dump_data,
  output logic                   dump_busy,
  output logic                   dump_done
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];

  function automatic logic [MAX_WR-1:0] addr_match(input logic [AW-1:0]        a,
                                                   input logic [NUM_WR-1:0]    en,
                                                   input logic [NUM_WR*AW-1:0] wa);
    logic [MAX_WR-1:0] m;
    m = '0;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      m[w] = en[w] && (wa[w*AW +: AW] == a);
    end
    return m;
  endfunction

  always_comb begin
    wr_sel_t wsel;
    wsel  = '0;
    mem_d = mem_q;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      wsel = wr_resolve(addr_match(AW'(r), wr_en, wr_addr));
      if (wsel.hit && !(ZERO_REG && r == 0)) begin
        mem_d[r] = wr_data[wsel.port*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Zero-register masking is applied last so it overrides a bypass hit on x0.
  always_comb begin
    wr_sel_t       bsel;
    logic [AW-1:0] ra;
    bsel    = '0;
    ra      = '0;
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra = rd_addr[i*AW +: AW];
      rd_data[i*XLEN +: XLEN] = mem_q[ra];
      if (BYPASS) begin
        bsel = wr_resolve(addr_match(ra, wr_en, wr_addr));
        if (bsel.hit) begin
          rd_data[i*XLEN +: XLEN] = wr_data[bsel.port*XLEN +: XLEN];
        end
      end
      if (ZERO_REG && ra == '0) begin
        rd_data[i*XLEN +: XLEN] = '0;
      end
    end
  end

  rf_dump_seq #(
    .DEPTH(DEPTH)
  ) u_dump_seq (
    .clock      (clock),
    .reset_n    (reset_n),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  assign dump_data = mem_q[dump_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: read/write vectors, bypass on/off, dump stream and reset abort.
module tb_regfile_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [2*AW-1:0]   rd_addr;
  logic [2*XLEN-1:0] rd_data, rd_data_nb;
  logic [1:0]        wr_en;
  logic [2*AW-1:0]   wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic              dump_start, dump_valid, dump_ready, dump_busy, dump_done;
  logic [AW-1:0]     dump_addr;
  logic [XLEN-1:0]   dump_data;
  logic              nb_start, nb_ready, nb_valid, nb_busy, nb_done;
  logic [AW-1:0]     nb_addr;
  logic [XLEN-1:0]   nb_data;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clock = ~clock;

  regfile_mp #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b1), .ZERO_REG(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
  );

  regfile_mp #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b0), .ZERO_REG(1'b1)
  ) dut_nb (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dump_start(nb_start), .dump_valid(nb_valid), .dump_ready(nb_ready),
    .dump_addr(nb_addr), .dump_data(nb_data), .dump_busy(nb_busy), .dump_done(nb_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1, n0, n1;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned beats, dones, found;
    logic        after_last;
    logic [31:0] exp_d;

    //          we     wa0    wa1    wd0           wd1           ra0    ra1    e0            e1            n0            n1
    vecs[0]  = '{2'b01, 5'd3,  5'd0,  32'hABCDEFFF, 32'h0,        5'd7,  5'd10, 32'h0,        32'h0,        32'h0,        32'h0};
    vecs[1]  = '{2'b01, 5'd5,  5'd0,  32'hFBCDE111, 32'h0,        5'd3,  5'd5,  32'hABCDEFFF, 32'hFBCDE111, 32'hABCDEFFF, 32'h0};
    vecs[2]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd5,  5'd3,  32'hFBCDE111, 32'hABCDEFFF, 32'hFBCDE111, 32'hABCDEFFF};
    vecs[3]  = '{2'b01, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[4]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd0,  5'd7,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[5]  = '{2'b11, 5'd9,  5'd9,  32'h11111111, 32'h22222222, 5'd9,  5'd9,  32'h22222222, 32'h22222222, 32'h0,        32'h0};
    vecs[6]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd9,  5'd5,  32'h22222222, 32'hFBCDE111, 32'h22222222, 32'hFBCDE111};
    vecs[7]  = '{2'b10, 5'd0,  5'd4,  32'h0,        32'h1234,     5'd4,  5'd3,  32'h1234,     32'hABCDEFFF, 32'h0,        32'hABCDEFFF};
    vecs[8]  = '{2'b01, 5'd4,  5'd0,  32'h5678,     32'h0,        5'd4,  5'd4,  32'h5678,     32'h5678,     32'h1234,     32'h1234};
    vecs[9]  = '{2'b11, 5'd6,  5'd0,  32'hAAAA,     32'hBBBB,     5'd0,  5'd6,  32'h0,        32'hAAAA,     32'h0,        32'h0};
    vecs[10] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd4,  5'd6,  32'h5678,     32'hAAAA,     32'h5678,     32'hAAAA};
    vecs[11] = '{2'b11, 5'd31, 5'd1,  32'hDEADBEEF, 32'h7,        5'd31, 5'd1,  32'hDEADBEEF, 32'h7,        32'h0,        32'h0};
    vecs[12] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd31, 5'd1,  32'hDEADBEEF, 32'h7,        32'hDEADBEEF, 32'h7};
    vecs[13] = '{2'b01, 5'd8,  5'd8,  32'h8888,     32'h9999,     5'd8,  5'd8,  32'h8888,     32'h8888,     32'h0,        32'h0};
    vecs[14] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd8,  5'd4,  32'h8888,     32'h5678,     32'h8888,     32'h5678};

    reset_n    = 1'b0;
    rd_addr    = {5'd9, 5'd3};
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    dump_start = 1'b0;
    dump_ready = 1'b0;
    nb_start   = 1'b0;
    nb_ready   = 1'b0;

    #2;
    check("rst_rd0", rd_data[31:0], 32'h0);
    check("rst_rd1", rd_data[63:32], 32'h0);
    check("rst_valid", {31'b0, dump_valid}, 32'h0);
    check("rst_busy", {31'b0, dump_busy}, 32'h0);
    check("rst_done", {31'b0, dump_done}, 32'h0);
    check("rst_addr", {27'b0, dump_addr}, 32'h0);
    check("rst_data", dump_data, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      wr_en   = vecs[i].we;
      wr_addr = {vecs[i].wa1, vecs[i].wa0};
      wr_data = {vecs[i].wd1, vecs[i].wd0};
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      check($sformatf("v%0d_byp_rd0", i), rd_data[31:0], vecs[i].e0);
      check($sformatf("v%0d_byp_rd1", i), rd_data[63:32], vecs[i].e1);
      check($sformatf("v%0d_nb_rd0", i), rd_data_nb[31:0], vecs[i].n0);
      check($sformatf("v%0d_nb_rd1", i), rd_data_nb[63:32], vecs[i].n1);
    end

    // Preload xi = i*0x10, two registers per cycle.
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      wr_en   = 2'b11;
      wr_addr = {5'(2*i+1), 5'(2*i)};
      wr_data = {32'((2*i+1)*16), 32'((2*i)*16)};
    end
    @(negedge clock);
    wr_en      = '0;
    dump_start = 1'b1;
    dump_ready = 1'b0;

    beats      = 0;
    dones      = 0;
    after_last = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clock);
      dump_start = (cyc == 9);
      dump_ready = (cyc % 2 == 1);
      wr_en      = (cyc == 4) ? 2'b01 : 2'b00;
      wr_addr    = {5'd0, 5'd2};
      wr_data    = {32'h0, 32'hCAFE};
      #1;
      if (dump_done) begin
        dones++;
        check("done_timing", {31'b0, after_last}, 32'h1);
      end
      after_last = 1'b0;
      if (dump_valid && dump_ready) begin
        exp_d = (beats == 2) ? 32'hCAFE : 32'(beats * 16);
        check($sformatf("beat%0d_addr", beats), {27'b0, dump_addr}, 32'(beats));
        check($sformatf("beat%0d_data", beats), dump_data, exp_d);
        beats++;
        if (beats == 32) after_last = 1'b1;
      end
    end
    dump_ready = 1'b0;
    wr_en      = '0;
    check("dump_beats", beats, 32'd32);
    check("dump_dones", dones, 32'd1);
    check("dump_idle_busy", {31'b0, dump_busy}, 32'h0);
    check("dump_idle_valid", {31'b0, dump_valid}, 32'h0);

    // Reset asserted in the middle of a dump.
    @(negedge clock);
    dump_start = 1'b1;
    dump_ready = 1'b1;
    found      = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clock);
      dump_start = 1'b0;
      #1;
      if (dump_valid && dump_addr == 5'd10) begin
        found = 1;
        break;
      end
    end
    check("reach_beat10", found, 32'd1);
    reset_n = 1'b0;
    rd_addr = {5'd9, 5'd5};
    #1;
    check("abort_valid", {31'b0, dump_valid}, 32'h0);
    check("abort_busy", {31'b0, dump_busy}, 32'h0);
    check("abort_done", {31'b0, dump_done}, 32'h0);
    check("abort_addr", {27'b0, dump_addr}, 32'h0);
    check("abort_rd0", rd_data[31:0], 32'h0);
    check("abort_rd1", rd_data[63:32], 32'h0);
    check("abort_nb_rd0", rd_data_nb[31:0], 32'h0);
    @(posedge clock);
    #1;
    check("abort_done_hold", {31'b0, dump_done}, 32'h0);
    @(negedge clock);
    reset_n    = 1'b1;
    rd_addr    = {5'd31, 5'd3};
    #1;
    check("post_rst_rd0", rd_data[31:0], 32'h0);
    check("post_rst_rd1", rd_data[63:32], 32'h0);
    check("post_rst_done", {31'b0, dump_done}, 32'h0);
    dump_start = 1'b1;
    dump_ready = 1'b0;
    @(negedge clock);
    dump_start = 1'b0;
    #1;
    check("restart_valid", {31'b0, dump_valid}, 32'h1);
    check("restart_addr", {27'b0, dump_addr}, 32'h0);
    check("restart_data", dump_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
